bcd_upcounter4: RTL

- Four-digit cascaded BCD up-counter for stopwatch-style elapsed-time display, e.g. mm:ss.
- Counts up with ripple-carry between digits, the counterpart to the borrow chain of the down-counting timer digits.
- Sits between the 1 Hz tick divider / debounced one-pulse buttons and the 7-segment scan driver.
- Holds a small run-control FSM: idle, run, pause, done.

---
 rtl/bcd_upcounter4_if.sv | 23 ++
 rtl/bcd_upcounter4.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bcd_upcounter4_if.sv
// Control pulses in, BCD digits and run status out; the counter sits on the slave side.
interface bcd_upcounter4_if;
  logic       tick;
  logic       start_pause;
  logic       clear;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       carry_out;
  logic       running;
  logic       done;

  modport master (
    output tick, start_pause, clear,
    input  digit0, digit1, digit2, digit3, carry_out, running, done
  );

  modport slave (
    input  tick, start_pause, clear,
    output digit0, digit1, digit2, digit3, carry_out, running, done
  );
endinterface

// File: rtl/bcd_upcounter4.sv
// Four-digit ripple-carry BCD up-counter with idle/run/pause/done control; digits update 1 cycle after tick.
// Optional UPCOUNTER_WRAP_EN: terminal count wraps to zero and keeps running instead of stopping in DONE.
module bcd_upcounter4 #(
  parameter int LIM0 = 9,
  parameter int LIM1 = 5,
  parameter int LIM2 = 9,
  parameter int LIM3 = 5
) (
  input  logic             clk,
  input  logic             rst,
  bcd_upcounter4_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [3:0][3:0] LIM = {4'(LIM3), 4'(LIM2), 4'(LIM1), 4'(LIM0)};

  state_t          state;
  logic [3:0][3:0] cnt;
  logic [3:0][3:0] cnt_inc;
  logic [4:0]      cy;
  logic            carry_q;
  logic            running_q;

  // Carry ripples through all four digits in one cycle; cy[4] marks the terminal tick.
  always_comb begin
    cy      = '0;
    cy[0]   = bus.tick;
    cnt_inc = cnt;
    for (int n = 0; n < 4; n++) begin
      if (cy[n]) begin
        if (cnt[n] == LIM[n]) begin
          cnt_inc[n] = 4'd0;
          cy[n+1]    = 1'b1;
        end else begin
          cnt_inc[n] = cnt[n] + 4'd1;
        end
      end
    end
  end

`ifdef UPCOUNTER_WRAP_EN
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      cnt       <= '0;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
      state     <= IDLE;
    end else begin
      carry_q <= 1'b0;
      case (state)
        IDLE, PAUSE: begin
          if (bus.start_pause) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.tick) cnt <= cnt_inc;
          carry_q <= cy[4];
          if (bus.start_pause) begin
            state     <= PAUSE;
            running_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done = 1'b0;
`else
  logic done_q;

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      cnt       <= '0;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      state     <= IDLE;
    end else begin
      carry_q <= 1'b0;
      case (state)
        IDLE, PAUSE: begin
          if (bus.start_pause) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          // Terminal tick wins over a coincident start_pause: digits freeze at max.
          if (cy[4]) begin
            carry_q   <= 1'b1;
            state     <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            if (bus.tick) cnt <= cnt_inc;
            if (bus.start_pause) begin
              state     <= PAUSE;
              running_q <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done = done_q;
`endif

  assign bus.digit0    = cnt[0];
  assign bus.digit1    = cnt[1];
  assign bus.digit2    = cnt[2];
  assign bus.digit3    = cnt[3];
  assign bus.carry_out = carry_q;
  assign bus.running   = running_q;

  for (genvar g = 0; g < 4; g++) begin : g_lim_chk
    a_digit_in_range: assert property (@(posedge clk) disable iff (rst) cnt[g] <= LIM[g]);
  end

endmodule
